hapara_axis_id_receiver: RTL and testbench

- AXI4-Stream slave endpoint that consumes work-item IDs produced by the hapara ID generator.
- Buffers IDs in a small FIFO and hands them one at a time to a compute core over a valid/ready pull port.
- Tracks work-group boundaries marked by TLAST.
- Applies a group barrier: the next group is not accepted until the core signals that it has finished the current one. `group_done` then pulses.

---
 rtl/hapara_id_pkg.sv | 19 +
 rtl/hapara_id_fifo.sv | 61 ++++++
 rtl/hapara_axis_id_receiver.sv | 94 +++++++++
 tb/tb_hapara_axis_id_receiver.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hapara_id_pkg.sv
// Shared types and default widths for the hapara work-item ID receiver.
package hapara_id_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    WAIT = 2'd2
  } state_e;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_CNT_WIDTH  = 16;

  typedef struct packed {
    logic                      last;
    logic [DEF_DATA_WIDTH-1:0] data;
  } id_entry_t;

endpackage

// File: rtl/hapara_id_fifo.sv
// Synchronous FIFO with registered full/empty and a hold register
// so the read port keeps its last popped word while empty.
module hapara_id_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wrEn,
  input  logic [WIDTH-1:0] wrData,
  output logic             full,
  input  logic             rdEn,
  output logic [WIDTH-1:0] rdData,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [AW:0]      count;
  logic [AW:0]      countNxt;
  logic [WIDTH-1:0] holdQ;
  logic             push;
  logic             pop;

  assign push = wrEn & ~full;
  assign pop  = rdEn & ~empty;

  assign countNxt = count
                  + {{AW{1'b0}}, push}
                  - {{AW{1'b0}}, pop};

  assign rdData = empty ? holdQ : mem[rdPtr];

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= wrData;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
      holdQ <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
        holdQ <= mem[rdPtr];
      end
      count <= countNxt;
      full  <= (countNxt == (AW+1)'(DEPTH));
      empty <= (countNxt == '0);
    end
  end

endmodule

// File: rtl/hapara_axis_id_receiver.sv
// AXI4-Stream work-item ID receiver with per-group barrier.
// Next group is held off until the core reports the current one done.
module hapara_axis_id_receiver
  import hapara_id_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [DATA_WIDTH-1:0] id_data,
  output logic                  id_last,
  input  logic                  core_done,
  output logic                  group_done,
  output logic [CNT_WIDTH-1:0]  id_count,
  output logic [CNT_WIDTH-1:0]  group_count,
  output logic                  busy
);

  state_e            state;
  logic              armedQ;
  logic              fifoFull;
  logic              fifoEmpty;
  logic              accept;
  logic [DATA_WIDTH:0] rdEntry;

  // armedQ keeps tready low while reset is held
  assign s_axis_tready = armedQ
                       & ((state == IDLE) | (state == RECV))
                       & ~fifoFull;
  assign accept   = s_axis_tvalid & s_axis_tready;
  assign id_valid = ~fifoEmpty;
  assign id_data  = rdEntry[DATA_WIDTH-1:0];
  assign id_last  = rdEntry[DATA_WIDTH];
  assign busy     = (state != IDLE);

  hapara_id_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (ACLK),
    .rst_n  (ARESETN),
    .wrEn   (accept),
    .wrData ({s_axis_tlast, s_axis_tdata}),
    .full   (fifoFull),
    .rdEn   (id_ready),
    .rdData (rdEntry),
    .empty  (fifoEmpty)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state       <= IDLE;
      armedQ      <= 1'b0;
      group_done  <= 1'b0;
      id_count    <= '0;
      group_count <= '0;
    end else begin
      armedQ     <= 1'b1;
      group_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            id_count <= CNT_WIDTH'(1);
            state    <= s_axis_tlast ? WAIT : RECV;
          end
        end
        RECV: begin
          if (accept) begin
            id_count <= id_count + 1'b1;
            if (s_axis_tlast) state <= WAIT;
          end
        end
        WAIT: begin
          if (core_done && fifoEmpty) begin
            state       <= IDLE;
            id_count    <= '0;
            group_done  <= 1'b1;
            group_count <= group_count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hapara_axis_id_receiver.sv
// Directed bench with an in-order scoreboard of accepted stream beats.
module tb_hapara_axis_id_receiver;

  logic        tb_ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        tvalid = 1'b0;
  logic        tready;
  logic [31:0] tdata = '0;
  logic        tlast = 1'b0;
  logic        idValid;
  logic        idReady = 1'b0;
  logic [31:0] idData;
  logic        idLast;
  logic        coreDone = 1'b0;
  logic        groupDone;
  logic [15:0] idCount;
  logic [15:0] groupCount;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int accCnt = 0;
  int popCnt = 0;
  int gdCnt  = 0;
  logic [32:0] sbq [$];
  logic [32:0] sbExp;

  always #5 tb_ACLK = ~tb_ACLK;

  hapara_axis_id_receiver dut (
    .ACLK          (tb_ACLK),
    .ARESETN       (ARESETN),
    .s_axis_tvalid (tvalid),
    .s_axis_tready (tready),
    .s_axis_tdata  (tdata),
    .s_axis_tlast  (tlast),
    .id_valid      (idValid),
    .id_ready      (idReady),
    .id_data       (idData),
    .id_last       (idLast),
    .core_done     (coreDone),
    .group_done    (groupDone),
    .id_count      (idCount),
    .group_count   (groupCount),
    .busy          (busy)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge tb_ACLK);
    #1;
  endtask

  task automatic sendBeat(input logic [31:0] d, input logic l);
    logic acc;
    acc = 1'b0;
    tvalid = 1'b1;
    tdata = d;
    tlast = l;
    for (int i = 0; i < 40; i++) begin
      acc = tready;
      tick();
      if (acc) break;
    end
    tvalid = 1'b0;
    tlast = 1'b0;
    if (!acc) chk("beatTimeout", 0, 1);
  endtask

  task automatic popOne();
    idReady = 1'b1;
    tick();
    idReady = 1'b0;
  endtask

  task automatic drain();
    idReady = 1'b1;
    for (int i = 0; i < 30 && idValid; i++) tick();
    idReady = 1'b0;
    chk("drainEmpty", {63'd0, idValid}, 0);
  endtask

  task automatic pulseDone();
    coreDone = 1'b1;
    tick();
    coreDone = 1'b0;
  endtask

  always @(negedge tb_ACLK) begin
    if (ARESETN) begin
      if (tvalid && tready) begin
        sbq.push_back({tlast, tdata});
        accCnt++;
      end
      if (idValid && idReady) begin
        if (sbq.size() == 0) begin
          chk("sbUnderflow", 1, 0);
        end else begin
          sbExp = sbq.pop_front();
          chk("sbData", {31'd0, idLast, idData}, {31'd0, sbExp});
        end
        popCnt++;
      end
      if (groupDone) gdCnt++;
    end
  end

  initial begin
    int accBefore;
    int gdBefore;
    int stalls;

    // reset values
    repeat (2) tick();
    chk("rstTready", {63'd0, tready}, 0);
    chk("rstIdValid", {63'd0, idValid}, 0);
    chk("rstIdData", {32'd0, idData}, 0);
    chk("rstIdLast", {63'd0, idLast}, 0);
    chk("rstGroupDone", {63'd0, groupDone}, 0);
    chk("rstIdCount", {48'd0, idCount}, 0);
    chk("rstGroupCount", {48'd0, groupCount}, 0);
    chk("rstBusy", {63'd0, busy}, 0);
    ARESETN = 1'b1;
    tick();
    chk("idleTready", {63'd0, tready}, 1);

    // single-beat group
    sendBeat(32'h1, 1'b1);
    chk("t1IdValid", {63'd0, idValid}, 1);
    chk("t1Tready", {63'd0, tready}, 0);
    chk("t1IdLast", {63'd0, idLast}, 1);
    chk("t1Busy", {63'd0, busy}, 1);
    chk("t1IdCount", {48'd0, idCount}, 1);
    popOne();
    chk("t1Empty", {63'd0, idValid}, 0);
    chk("t1NoDoneYet", {63'd0, groupDone}, 0);
    pulseDone();
    chk("t1GroupDone", {63'd0, groupDone}, 1);
    chk("t1GroupCount", {48'd0, groupCount}, 1);
    chk("t1IdCountClr", {48'd0, idCount}, 0);
    chk("t1BusyIdle", {63'd0, busy}, 0);
    tick();
    chk("t1PulseEnd", {63'd0, groupDone}, 0);
    chk("t1HoldData", {32'd0, idData}, 32'h1);

    // group of 8, fill to full with id_ready low
    for (int i = 1; i <= 4; i++) sendBeat(32'(i), 1'b0);
    chk("t2FullTready", {63'd0, tready}, 0);
    chk("t2Count4", {48'd0, idCount}, 4);
    tvalid = 1'b1;
    tdata = 32'h5;
    tick();
    tick();
    chk("t2StillFull", {63'd0, tready}, 0);
    chk("t2NoAccept", {48'd0, idCount}, 4);
    popOne();
    chk("t2Reraise", {63'd0, tready}, 1);
    tick();
    tvalid = 1'b0;
    chk("t2Count5", {48'd0, idCount}, 5);
    chk("t2FullAgain", {63'd0, tready}, 0);
    idReady = 1'b1;
    sendBeat(32'h6, 1'b0);
    sendBeat(32'h7, 1'b0);
    sendBeat(32'h8, 1'b1);
    idReady = 1'b0;
    chk("t2Count8", {48'd0, idCount}, 8);
    chk("t2WaitTready", {63'd0, tready}, 0);

    // barrier: next group offered straight away
    tvalid = 1'b1;
    tdata = 32'h101;
    tlast = 1'b0;
    accBefore = accCnt;
    drain();
    repeat (3) tick();
    chk("t3NoLeak", 64'(accCnt), 64'(accBefore));
    chk("t3BusyWait", {63'd0, busy}, 1);
    chk("t3CountHeld", {48'd0, idCount}, 8);
    chk("t3GcBefore", {48'd0, groupCount}, 1);
    chk("t3Popped", 64'(popCnt), 9);
    pulseDone();
    chk("t3GroupDone", {63'd0, groupDone}, 1);
    chk("t3GroupCount", {48'd0, groupCount}, 2);
    chk("t3IdCountClr", {48'd0, idCount}, 0);
    chk("t3TreadyBack", {63'd0, tready}, 1);
    tick();
    tvalid = 1'b0;
    chk("t3Restart", {48'd0, idCount}, 1);
    chk("t3FirstValid", {63'd0, idValid}, 1);
    chk("t3FirstData", {32'd0, idData}, 32'h101);

    // early core_done is ignored
    sendBeat(32'h102, 1'b0);
    sendBeat(32'h103, 1'b1);
    popOne();
    gdBefore = gdCnt;
    pulseDone();
    tick();
    chk("t4NoPulse", 64'(gdCnt), 64'(gdBefore));
    chk("t4StillWait", {63'd0, busy}, 1);
    chk("t4Gc", {48'd0, groupCount}, 2);
    chk("t4Count3", {48'd0, idCount}, 3);
    drain();
    pulseDone();
    chk("t4GroupDone", {63'd0, groupDone}, 1);
    chk("t4GroupCount", {48'd0, groupCount}, 3);

    // full throughput, 16 beats
    tick();
    stalls = 0;
    idReady = 1'b1;
    tvalid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tdata = 32'h200 + 32'(i);
      tlast = (i == 15);
      if (!tready) stalls++;
      tick();
    end
    tvalid = 1'b0;
    tlast = 1'b0;
    chk("t5NoStall", 64'(stalls), 0);
    chk("t5Count16", {48'd0, idCount}, 16);
    chk("t5TreadyDrop", {63'd0, tready}, 0);
    drain();
    chk("t5SbEmpty", 64'(sbq.size()), 0);
    pulseDone();
    chk("t5GroupCount", {48'd0, groupCount}, 4);

    // reset mid-group
    tick();
    for (int i = 1; i <= 3; i++) sendBeat(32'h300 + 32'(i), 1'b0);
    chk("t6Count3", {48'd0, idCount}, 3);
    chk("t6Busy", {63'd0, busy}, 1);
    gdBefore = gdCnt;
    #2 ARESETN = 1'b0;
    #1;
    chk("t6IdValid", {63'd0, idValid}, 0);
    chk("t6Busy0", {63'd0, busy}, 0);
    chk("t6IdCount0", {48'd0, idCount}, 0);
    chk("t6Gc0", {48'd0, groupCount}, 0);
    chk("t6Tready0", {63'd0, tready}, 0);
    sbq.delete();
    repeat (2) tick();
    ARESETN = 1'b1;
    repeat (2) tick();
    chk("t6NoPulse", 64'(gdCnt), 64'(gdBefore));
    sendBeat(32'h401, 1'b1);
    chk("t6NewCount", {48'd0, idCount}, 1);
    chk("t6NewData", {32'd0, idData}, 32'h401);
    popOne();
    pulseDone();
    chk("t6NewGc", {48'd0, groupCount}, 1);
    chk("t6SbEnd", 64'(sbq.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
